// File: rtl/dispense_sequencer.sv
// Dispense controller: opens the flap, runs a counted burst of step pulses with the
// agitator on, closes the flap and reports completion. It also generates the flap servo PWM.
module dispense_sequencer #(
   parameter int CNT_W        = 24,
   parameter int SERVO_PERIOD = 240000,
   parameter int SERVO_OPEN   = 24000,
   parameter int SERVO_CLOSED = 12000,
   parameter int SETTLE       = 6000000,
   parameter int STEP_HALF    = 3000,
   parameter int STEPS_SMALL  = 200,
   parameter int STEPS_MED    = 400,
   parameter int STEPS_LARGE  = 800
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_amount,
   input  logic       cmd_dir,
   input  logic       abort,
   output logic       cmd_ready,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic       err,
   output logic       servo_pwm,
   output logic       step,
   output logic       step_dir,
   output logic       dc_fwd,
   output logic       dc_rev
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPEN,
      S_STEP,
      S_CLOSE,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(STEP_HALF - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(SERVO_PERIOD - 1);
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic [CNT_W-1:0] steps_last_q, steps_last_d;
   logic             phase_q, phase_d;
   logic             dir_q, dir_d;
   logic             abort_flag_q, abort_flag_d;
   logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             servo_pwm_q, servo_pwm_d;
   logic             step_q, step_d;
   logic             dc_fwd_q, dc_fwd_d;
   logic             dc_rev_q, dc_rev_d;
   logic             flap_open;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      step_cnt_d   = step_cnt_q;
      steps_last_d = steps_last_q;
      phase_d      = phase_q;
      dir_d        = dir_q;
      abort_flag_d = abort_flag_q;
      err_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_amount == 2'b11) begin
                  err_d = 1'b1;
               end else begin
                  state_d      = S_OPEN;
                  cnt_d        = '0;
                  dir_d        = cmd_dir;
                  abort_flag_d = 1'b0;
                  case (cmd_amount)
                     2'b00:   steps_last_d = CNT_W'(STEPS_SMALL - 1);
                     2'b01:   steps_last_d = CNT_W'(STEPS_MED - 1);
                     default: steps_last_d = CNT_W'(STEPS_LARGE - 1);
                  endcase
               end
            end
         end
         S_OPEN: begin
            if (abort) begin
               state_d      = S_CLOSE;
               cnt_d        = '0;
               abort_flag_d = 1'b1;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d    = S_STEP;
               cnt_d      = '0;
               step_cnt_d = '0;
               phase_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_STEP: begin
            // phase_q high = first half of a step period; the burst ends after the low half of the last step
            if (abort) begin
               state_d      = S_CLOSE;
               cnt_d        = '0;
               abort_flag_d = 1'b1;
            end else if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (phase_q) begin
                  phase_d = 1'b0;
               end else if (step_cnt_q == steps_last_q) begin
                  state_d = S_CLOSE;
               end else begin
                  step_cnt_d = step_cnt_q + ONE;
                  phase_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_CLOSE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are derived from next-state values so the registered outputs line up with state_q.
   always_comb begin
      flap_open   = (state_d == S_OPEN) || (state_d == S_STEP);
      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      step_d      = (state_d == S_STEP) && phase_d;
      dc_fwd_d    = (state_d == S_STEP) && !dir_d;
      dc_rev_d    = (state_d == S_STEP) && dir_d;
      pwm_cnt_d   = (pwm_cnt_q == PERIOD_LAST) ? '0 : pwm_cnt_q + ONE;
      width_d     = width_q;
      if (pwm_cnt_q == PERIOD_LAST) begin
         width_d = flap_open ? CNT_W'(SERVO_OPEN) : CNT_W'(SERVO_CLOSED);
      end
      servo_pwm_d = (pwm_cnt_d < width_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         step_cnt_q   <= '0;
         steps_last_q <= '0;
         phase_q      <= 1'b0;
         dir_q        <= 1'b0;
         abort_flag_q <= 1'b0;
         pwm_cnt_q    <= '0;
         width_q      <= CNT_W'(SERVO_CLOSED);
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         servo_pwm_q  <= 1'b0;
         step_q       <= 1'b0;
         dc_fwd_q     <= 1'b0;
         dc_rev_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         step_cnt_q   <= step_cnt_d;
         steps_last_q <= steps_last_d;
         phase_q      <= phase_d;
         dir_q        <= dir_d;
         abort_flag_q <= abort_flag_d;
         pwm_cnt_q    <= pwm_cnt_d;
         width_q      <= width_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         servo_pwm_q  <= servo_pwm_d;
         step_q       <= step_d;
         dc_fwd_q     <= dc_fwd_d;
         dc_rev_q     <= dc_rev_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign aborted   = abort_flag_q;
   assign err       = err_q;
   assign servo_pwm = servo_pwm_q;
   assign step      = step_q;
   assign step_dir  = dir_q;
   assign dc_fwd    = dc_fwd_q;
   assign dc_rev    = dc_rev_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: a timeline model (accept/abort times -> expected windows)
// is compared every cycle, plus literal checks on latencies, pulse counts and servo widths.
module tb_dispense_sequencer;

   localparam int PER = 100;
   localparam int WO  = 20;
   localparam int WC  = 10;
   localparam int S   = 8;
   localparam int H   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_amount = 2'b00;
   logic       cmd_dir = 1'b0;
   logic       abort = 1'b0;
   logic       cmd_ready, busy, done, aborted, err, servo_pwm, step, step_dir, dc_fwd, dc_rev;

   int nVectors = 0;
   int nMiscompares = 0;
   bit checkEn = 1'b0;

   dispense_sequencer #(
      .CNT_W(16), .SERVO_PERIOD(PER), .SERVO_OPEN(WO), .SERVO_CLOSED(WC),
      .SETTLE(S), .STEP_HALF(H), .STEPS_SMALL(3), .STEPS_MED(5), .STEPS_LARGE(8)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_amount(cmd_amount),
      .cmd_dir(cmd_dir), .abort(abort), .cmd_ready(cmd_ready), .busy(busy),
      .done(done), .aborted(aborted), .err(err), .servo_pwm(servo_pwm),
      .step(step), .step_dir(step_dir), .dc_fwd(dc_fwd), .dc_rev(dc_rev)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0b expected %0b at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Timeline model: T counts clock edges since reset release; everything the outputs
   // should do is a window of T derived from the accept and abort times.
   int T = 0;
   bit mActive = 0;
   int mA = 0, mStepStart = 0, mStepEnd = 0, mDoneAt = 0, mErrAt = -1;
   bit mDir = 0, mAborted = 0;
   int mWidth = WC;

   always @(posedge clk or posedge rst) begin : modelProc
      int tn, nA, nStart, nEnd, nDoneAt, nErrAt, n;
      bit nActive, nDir, nAborted;
      if (rst) begin
         T <= 0; mActive <= 0; mDir <= 0; mAborted <= 0; mErrAt <= -1; mWidth <= WC;
         mA <= 0; mStepStart <= 0; mStepEnd <= 0; mDoneAt <= 0;
      end else begin
         tn = T + 1;
         nActive = mActive; nA = mA; nStart = mStepStart; nEnd = mStepEnd;
         nDoneAt = mDoneAt; nErrAt = mErrAt; nDir = mDir; nAborted = mAborted;
         if (!mActive || T > mDoneAt) begin
            if (cmd_valid) begin
               if (cmd_amount == 2'b11) begin
                  nErrAt = tn;
               end else begin
                  n = (cmd_amount == 2'b00) ? 3 : (cmd_amount == 2'b01) ? 5 : 8;
                  nActive = 1; nA = tn; nStart = tn + S; nEnd = tn + S + 2 * n * H;
                  nDoneAt = tn + 2 * S + 2 * n * H; nDir = cmd_dir; nAborted = 0;
               end
            end
         end else if (abort && T < mStepEnd) begin
            nEnd = tn; nDoneAt = tn + S; nAborted = 1;
         end
         if (tn % PER == 0)
            mWidth <= (nActive && tn >= nA && tn < nEnd) ? WO : WC;
         T <= tn; mActive <= nActive; mA <= nA; mStepStart <= nStart; mStepEnd <= nEnd;
         mDoneAt <= nDoneAt; mErrAt <= nErrAt; mDir <= nDir; mAborted <= nAborted;
      end
   end

   // Per-cycle comparison of the whole output vector against the model.
   always @(negedge clk) begin : compareProc
      bit inStep, eBusy, eDone, eStep, ePwm, eErr;
      int expv, actv;
      if (checkEn && !rst) begin
         inStep = mActive && T >= mStepStart && T < mStepEnd;
         eStep  = inStep && ((T - mStepStart) % (2 * H)) < H;
         eBusy  = mActive && T >= mA && T <= mDoneAt;
         eDone  = mActive && T == mDoneAt;
         eErr   = (T == mErrAt);
         ePwm   = (T != 0) && ((T % PER) < mWidth);
         expv = int'({!eBusy, eBusy, eDone, eDone & mAborted, eErr, ePwm, eStep, mDir,
                      inStep & !mDir, inStep & mDir});
         actv = int'({cmd_ready, busy, done, done & aborted, err, servo_pwm, step, step_dir,
                      dc_fwd, dc_rev});
         checkOutput("cycle", actv, expv);
      end
   end

   // Observers of DUT activity used by the literal checks.
   int pulses = 0, fwdCycles = 0, revCycles = 0, errCount = 0, runLen = 0;
   bit stepPrev = 0;
   int runs[$];

   always @(negedge clk) begin
      if (rst) begin
         stepPrev <= 0;
         runLen <= 0;
      end else begin
         if (step && !stepPrev) pulses <= pulses + 1;
         stepPrev <= step;
         if (dc_fwd) fwdCycles <= fwdCycles + 1;
         if (dc_rev) revCycles <= revCycles + 1;
         if (err) errCount <= errCount + 1;
         if (servo_pwm) begin
            runLen <= runLen + 1;
         end else if (runLen != 0) begin
            runs.push_back(runLen);
            runLen <= 0;
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] amount, input logic dir);
      cmd_valid = 1'b1;
      cmd_amount = amount;
      cmd_dir = dir;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_amount = 2'b00;
   endtask

   task automatic waitDone(input int limit, output int cycles, output int ab);
      cycles = 0;
      while (!done && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
      ab = int'(aborted);
      checkOutput("doneSeen", int'(done), 1);
   endtask

   task automatic maxRunFrom(input int first, output int m);
      m = 0;
      for (int i = first; i < runs.size(); i++)
         if (runs[i] > m) m = runs[i];
   endtask

   initial begin
      int c, ab, p0, f0, r0, e0, rq, m, guard;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkEn = 1'b1;
      checkOutput("rstReady", int'(cmd_ready), 1);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstPwm", int'(servo_pwm), 0);

      // idle: servo at closed width, no motion
      repeat (300) @(negedge clk);
      checkOutput("idlePulses", pulses, 0);
      checkOutput("idleRun", (runs.size() > 0) ? runs[runs.size() - 1] : -1, WC);

      // medium, dir 0, timed so a PWM period starts while the flap is open
      guard = 0;
      while (T % PER != 80 && guard < 200) begin @(negedge clk); guard++; end
      p0 = pulses; f0 = fwdCycles; r0 = revCycles; rq = runs.size();
      applyStimulus(2'b01, 1'b0);
      waitDone(500, c, ab);
      checkOutput("medLatency", c + 1, 37);
      checkOutput("medAborted", ab, 0);
      repeat (100) @(negedge clk);
      checkOutput("medPulses", pulses - p0, 5);
      checkOutput("medFwd", fwdCycles - f0, 20);
      checkOutput("medRev", revCycles - r0, 0);
      maxRunFrom(rq, m);
      checkOutput("openWidth", m, WO);

      // large, dir 1
      p0 = pulses; f0 = fwdCycles; r0 = revCycles;
      applyStimulus(2'b10, 1'b1);
      waitDone(500, c, ab);
      checkOutput("lrgLatency", c + 1, 49);
      checkOutput("lrgPulses", pulses - p0, 8);
      checkOutput("lrgRev", revCycles - r0, 32);
      checkOutput("lrgFwd", fwdCycles - f0, 0);
      checkOutput("lrgDir", int'(step_dir), 1);
      repeat (120) @(negedge clk);

      // illegal amount
      p0 = pulses; e0 = errCount;
      applyStimulus(2'b11, 1'b0);
      repeat (5) @(negedge clk);
      checkOutput("illErr", errCount - e0, 1);
      checkOutput("illPulses", pulses - p0, 0);
      checkOutput("illBusy", int'(busy), 0);

      // small with abort after the first pulse
      p0 = pulses;
      applyStimulus(2'b00, 1'b0);
      guard = 0;
      while (!((pulses - p0) >= 1 && !step) && guard < 100) begin @(negedge clk); guard++; end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abortDc", int'(dc_fwd), 0);
      waitDone(100, c, ab);
      checkOutput("abortLatency", c + 1, 9);
      checkOutput("abortFlag", ab, 1);
      checkOutput("abortPulses", pulses - p0, 1);
      repeat (3) @(negedge clk);
      applyStimulus(2'b00, 1'b0);
      waitDone(500, c, ab);
      checkOutput("smlLatency", c + 1, 29);
      checkOutput("smlAborted", ab, 0);
      repeat (10) @(negedge clk);

      // asynchronous reset while a step pulse is high
      applyStimulus(2'b10, 1'b1);
      guard = 0;
      while (!step && guard < 100) begin @(negedge clk); guard++; end
      #1 rst = 1'b1;
      #1;
      checkOutput("rstMidStep", int'(step), 0);
      checkOutput("rstMidRev", int'(dc_rev), 0);
      checkOutput("rstMidBusy", int'(busy), 0);
      checkOutput("rstMidDir", int'(step_dir), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (250) @(negedge clk);
      checkOutput("postRstRun", (runs.size() > 0) ? runs[runs.size() - 1] : -1, WC);
      p0 = pulses;
      applyStimulus(2'b01, 1'b0);
      waitDone(500, c, ab);
      checkOutput("postLatency", c + 1, 37);
      checkOutput("postAborted", ab, 0);
      repeat (5) @(negedge clk);
      checkOutput("postPulses", pulses - p0, 5);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/dispense_sequencer.md
# dispense_sequencer

Parametrised dispense controller for the candy/snack dispenser. It accepts one dispense command at a time from the Raspberry Pi command decode, then runs a fixed sequence: open the flap servo, issue a counted burst of stepper pulses with the DC agitator running, close the flap, and report completion. It generates its own servo PWM and step timing with configurable counts, supports abort, and replaces the free-running per-state motor outputs in the top level.

## Interface
- CNT_W, 24: width of all internal timing counters; every cycle-count parameter must be < 2^CNT_W.
- SERVO_PERIOD, 240000: servo PWM period in clk cycles (20 ms at 12 MHz).
- SERVO_OPEN, 24000: servo high time for flap open (2 ms).
- SERVO_CLOSED, 12000: servo high time for flap closed (1 ms).
- SETTLE, 6000000: wait after each flap move, in cycles.
- STEP_HALF, 3000: high and low time of each step pulse, in cycles.
- STEPS_SMALL, 200 / STEPS_MED, 400 / STEPS_LARGE, 800: step counts per amount code; each ≥1.
- clk  in  1  system clock (clk12M in the top level).
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request. Synchronous to clk; synchronisation is done upstream.
- cmd_amount  in  2  00 small, 01 medium, 10 large, 11 illegal.
- cmd_dir  in  1  stepper/agitator direction for this command.
- abort  in  1  level; terminates an active dispense.
- cmd_ready  out  1  high only in IDLE.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at the end of every accepted command.
- aborted  out  1  valid with done; 1 if the command was aborted.
- err  out  1  one-cycle pulse when an illegal amount is offered.
- servo_pwm  out  1  flap servo PWM.
- step  out  1  stepper step.
- step_dir  out  1  stepper direction.
- dc_fwd, dc_rev  out  1 each  agitator drive; never both high.

## Operation
- FSM states: IDLE, OPEN, STEP, CLOSE, DONE.
- IDLE: on cmd_valid && cmd_amount != 11, latch the amount's step count and cmd_dir, then go to OPEN. On cmd_valid && cmd_amount == 11, pulse err for 1 cycle, stay in IDLE, and start no motion.
- OPEN: flap target is open. Wait SETTLE cycles, then go to STEP.
- STEP: run N step periods, each STEP_HALF cycles high then STEP_HALF low. After the low phase of step N, go to CLOSE. During STEP, dc_fwd = ~dir and dc_rev = dir; otherwise both are 0.
- CLOSE: flap target is closed, step is 0, DC motor is off. Wait SETTLE cycles, then go to DONE.
- DONE: done = 1 for one cycle, aborted holds the abort flag, then go to IDLE. The abort flag clears on the next accept.
- step_dir holds the latched dir from accept until the next accept, so it is stable SETTLE cycles before the first step edge.
- abort sampled high in OPEN or STEP: go to CLOSE on the next cycle, truncate any step pulse (step is low from the next cycle), turn the DC motor off, and set the aborted flag.
- abort in IDLE, CLOSE or DONE is ignored. If abort and cmd_valid are both high in IDLE, the command is accepted.
- Servo PWM runs continuously, including in IDLE:
  - The period counter counts 0..SERVO_PERIOD-1 and wraps.
  - servo_pwm = (counter < active_width).
  - active_width reloads from the flap target only when the counter wraps to 0, so there are no runt pulses.

## Timing
- All outputs are registered.
- Reset values: state IDLE, cmd_ready 1, busy 0, done 0, aborted 0, err 0, step 0, step_dir 0, dc_fwd 0, dc_rev 0, servo_pwm 0, PWM counter 0, active_width SERVO_CLOSED.
- Accept edge at cycle k:
  - busy = 1 and cmd_ready = 0 from k+1.
  - First step rising edge at k+1+SETTLE.
  - done pulse at cycle k+1+2·SETTLE+2·N·STEP_HALF.
  - cmd_ready = 1 at the cycle after done.
- err is asserted in the cycle after the illegal cmd_valid is sampled.
- Abort sampled at cycle a: step, dc_fwd and dc_rev are 0 from a+1, state is CLOSE from a+1, done is at a+1+SETTLE.
- A flap target change is visible on servo_pwm within 1 to SERVO_PERIOD cycles.
- Asynchronous reset mid-operation: all outputs take their reset values immediately, the flap target returns to closed, and the latched command is discarded.

## Test plan
Directed scenarios use SERVO_PERIOD=100, SERVO_OPEN=20, SERVO_CLOSED=10, SETTLE=8, STEP_HALF=2, STEPS 3/5/8.
- Reset then idle 300 cycles -> servo_pwm high 10 of every 100 cycles, step/dc = 0, cmd_ready = 1.
- Medium command (amount 01, dir 0) accepted at cycle k:
  - Exactly 5 step pulses, each 2 cycles high.
  - dc_fwd high throughout STEP, dc_rev 0.
  - done at k+37 with aborted 0.
  - servo high time 20 while open, with no period shorter than 100.
- Large command with dir 1 -> 8 step pulses, step_dir 1, dc_rev high during STEP, done at k+49.
- Amount 11 offered -> err high for 1 cycle, busy stays 0, no step pulses, servo stays at 10.
- Small command, abort after 1 step pulse (in STEP):
  - step drops the next cycle and dc turns off.
  - done 9 cycles after the abort sample, aborted = 1.
  - The next command completes with aborted = 0.
- rst asserted mid-STEP with step high -> step, dc and busy go to 0 immediately. After release the servo returns to width 10 and a new command runs normally.
